// File: rtl/calculator_pkg.sv
// Shared opcode encoding, FSM state codes and width helpers for the calculator core.
package calculator_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpNot = 4'd5,
        OpShl = 4'd6,
        OpShr = 4'd7,
        OpSra = 4'd8,
        OpMul = 4'd9,
        OpDiv = 4'd10
    } opcode_e;

    // StEval is the one-cycle single-cycle-ALU stage between accept and DONE.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEval = 2'd1;
    localparam logic [1:0] StExec = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam int unsigned DefaultWordLength = 8;

    function automatic int unsigned shamt_width(input int unsigned word_length);
        return $clog2(word_length);
    endfunction

    localparam int unsigned DefaultShamtWidth = shamt_width(DefaultWordLength);

endpackage

// File: rtl/calculator_core_if.sv
// Operand/opcode request and result handshake bundle of the calculator core.
interface calculator_core_if #(
    parameter int unsigned Word_Length = 8
);
    logic [Word_Length-1:0] A;
    logic [Word_Length-1:0] B;
    logic [3:0]             Control;
    logic                   In_Valid;
    logic                   In_Ready;
    logic [Word_Length-1:0] C;
    logic [Word_Length-1:0] C_High;
    logic                   Carry;
    logic                   Overflow;
    logic                   Zero;
    logic                   Error;
    logic                   Out_Valid;
    logic                   Out_Ready;

    modport master (
        output A, B, Control, In_Valid, Out_Ready,
        input  In_Ready, C, C_High, Carry, Overflow, Zero, Error, Out_Valid
    );

    modport slave (
        input  A, B, Control, In_Valid, Out_Ready,
        output In_Ready, C, C_High, Carry, Overflow, Zero, Error, Out_Valid
    );
endinterface

// File: rtl/calc_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, Word_Length steps per op.
module calc_muldiv #(
    parameter int unsigned Word_Length = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   div_i,
    input  logic [Word_Length-1:0] a_i,
    input  logic [Word_Length-1:0] b_i,
    output logic                   done_o,
    output logic [Word_Length-1:0] lo_o,
    output logic [Word_Length-1:0] hi_o
);
    localparam int unsigned W    = Word_Length;
    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    logic [2*W-1:0]  acc_q, acc_d, step_acc;
    logic [W-1:0]    b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            div_q, div_d;
    logic            done_q, done_d;

    logic [W:0] mul_sum;
    logic [W:0] div_rem;
    logic [W:0] div_diff;

    // Divide: partial remainder is the upper half after a one-bit left shift.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q};
    assign div_rem  = acc_q[2*W-1:W-1];
    assign div_diff = div_rem - {1'b0, b_q};

    always_comb begin
        step_acc = acc_q;
        if (div_q) begin
            if (div_rem >= {1'b0, b_q}) begin
                step_acc = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                step_acc = {div_rem[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            step_acc = {mul_sum, acc_q[W-1:1]};
        end else begin
            step_acc = {1'b0, acc_q[2*W-1:1]};
        end
    end

    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;
        done_d = 1'b0;
        if (start_i) begin
            acc_d  = {{W{1'b0}}, a_i};
            b_d    = b_i;
            div_d  = div_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = step_acc;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign lo_o   = acc_q[W-1:0];
    assign hi_o   = acc_q[2*W-1:W];

endmodule

// File: rtl/calculator_core.sv
// Handshaked calculator: FSM, single-cycle ALU, iterative MUL/DIV and registered result.
module calculator_core
    import calculator_pkg::*;
#(
    parameter int unsigned Word_Length = 8
) (
    input  logic               clk,
    input  logic               reset,
    calculator_core_if.slave   bus
);
    localparam int unsigned W      = Word_Length;
    localparam int unsigned ShamtW = shamt_width(W);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] a_q, b_q;
    logic [3:0]   op_q;

    logic [W-1:0] c_q, c_d, c_high_q, c_high_d;
    logic         carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;
    logic         out_valid_q, out_valid_d;

    logic accept, is_iter, md_start, md_done;
    logic [W-1:0] md_lo, md_hi;

    assign accept   = bus.In_Valid && (state_q == StIdle);
    assign is_iter  = (bus.Control == OpMul) || ((bus.Control == OpDiv) && (bus.B != '0));
    assign md_start = accept && is_iter;

    calc_muldiv #(
        .Word_Length (W)
    ) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .start_i (md_start),
        .div_i   (bus.Control == OpDiv),
        .a_i     (bus.A),
        .b_i     (bus.B),
        .done_o  (md_done),
        .lo_o    (md_lo),
        .hi_o    (md_hi)
    );

    logic [ShamtW-1:0] shamt;
    logic [W:0]        add_res, sub_res;
    logic [W-1:0]      alu_c, alu_ch;
    logic              alu_carry, alu_ovf, alu_err;

    assign shamt   = b_q[ShamtW-1:0];
    assign add_res = {1'b0, a_q} + {1'b0, b_q};
    assign sub_res = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_c     = '0;
        alu_ch    = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op_q)
            OpAdd: begin
                alu_c     = add_res[W-1:0];
                alu_carry = add_res[W];
                alu_ovf   = (a_q[W-1] == b_q[W-1]) && (add_res[W-1] != a_q[W-1]);
            end
            OpSub: begin
                alu_c     = sub_res[W-1:0];
                alu_carry = sub_res[W];
                alu_ovf   = (a_q[W-1] != b_q[W-1]) && (sub_res[W-1] != a_q[W-1]);
            end
            OpAnd: alu_c = a_q & b_q;
            OpOr:  alu_c = a_q | b_q;
            OpXor: alu_c = a_q ^ b_q;
            OpNot: alu_c = ~a_q;
            OpShl: alu_c = a_q << shamt;
            OpShr: alu_c = a_q >> shamt;
            OpSra: alu_c = $unsigned($signed(a_q) >>> shamt);
            // Only a zero divisor reaches the single-cycle path for DIV.
            OpDiv: begin
                alu_c   = '1;
                alu_ch  = a_q;
                alu_err = 1'b1;
            end
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = is_iter ? StExec : StEval;
            StEval: state_d = StDone;
            StExec: if (md_done) state_d = StDone;
            StDone: if (bus.Out_Ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        c_d         = c_q;
        c_high_d    = c_high_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        if (state_q == StEval) begin
            c_d         = alu_c;
            c_high_d    = alu_ch;
            carry_d     = alu_carry;
            ovf_d       = alu_ovf;
            zero_d      = (alu_c == '0);
            err_d       = alu_err;
            out_valid_d = 1'b1;
        end else if ((state_q == StExec) && md_done) begin
            c_d         = md_lo;
            c_high_d    = md_hi;
            carry_d     = (op_q == OpMul) && (md_hi != '0);
            ovf_d       = 1'b0;
            zero_d      = (md_lo == '0);
            err_d       = 1'b0;
            out_valid_d = 1'b1;
        end else if ((state_q == StDone) && bus.Out_Ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            c_q         <= '0;
            c_high_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (accept) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.Control;
            end
            c_q         <= c_d;
            c_high_q    <= c_high_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.In_Ready  = (state_q == StIdle);
    assign bus.C         = c_q;
    assign bus.C_High    = c_high_q;
    assign bus.Carry     = carry_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Zero      = zero_q;
    assign bus.Error     = err_q;
    assign bus.Out_Valid = out_valid_q;

endmodule

// File: tb/tb_calculator_core.sv
// Directed self-checking bench for calculator_core at Word_Length = 8.
module tb_calculator_core;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   lat;
    bit   seen_valid;

    calculator_core_if #(.Word_Length(8)) bus ();

    calculator_core #(
        .Word_Length (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept one op, then count edges until Out_Valid (-1 if it never comes).
    task automatic do_op(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b,
                         output int latency);
        int n;
        n = 0;
        while (!bus.In_Ready && n < 50) begin
            step();
            n++;
        end
        bus.Control  = ctl;
        bus.A        = a;
        bus.B        = b;
        bus.In_Valid = 1'b1;
        step();
        bus.In_Valid = 1'b0;
        latency = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.Out_Valid === 1'b1) begin
                latency = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        bus.Out_Ready = 1'b1;
        step();
        bus.Out_Ready = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.Control  = '0;
        bus.In_Valid = 1'b0;
        bus.Out_Ready = 1'b0;
        step();
        step();
        chk("rst_c", bus.C, 0);
        chk("rst_chigh", bus.C_High, 0);
        chk("rst_flags", {bus.Carry, bus.Overflow, bus.Zero, bus.Error, bus.Out_Valid}, 5'b00100);
        reset = 1'b1;
        step();
        chk("rst_in_ready", bus.In_Ready, 1);

        // ADD 200+100
        do_op(4'd0, 8'd200, 8'd100, lat);
        chk("add1_lat", lat, 1);
        chk("add1_c", bus.C, 8'h2C);
        chk("add1_cvz", {bus.Carry, bus.Overflow, bus.Zero, bus.Error}, 4'b1000);
        chk("add1_in_ready", bus.In_Ready, 0);
        handshake();
        chk("add1_hs_ready", {bus.In_Ready, bus.Out_Valid}, 2'b10);

        // ADD 100+100 signed overflow
        do_op(4'd0, 8'd100, 8'd100, lat);
        chk("add2_c", bus.C, 8'hC8);
        chk("add2_cvz", {bus.Carry, bus.Overflow, bus.Zero, bus.Error}, 4'b0100);
        handshake();

        // SUB 5-7 and 9-9
        do_op(4'd1, 8'd5, 8'd7, lat);
        chk("sub1_c", bus.C, 8'hFE);
        chk("sub1_cvz", {bus.Carry, bus.Overflow, bus.Zero, bus.Error}, 4'b1000);
        handshake();
        do_op(4'd1, 8'd9, 8'd9, lat);
        chk("sub2_c", bus.C, 8'h00);
        chk("sub2_cvz", {bus.Carry, bus.Overflow, bus.Zero, bus.Error}, 4'b0010);
        handshake();

        // MUL 200*3 = 0x258
        do_op(4'd9, 8'd200, 8'd3, lat);
        chk("mul_lat", lat, 9);
        chk("mul_c", bus.C, 8'h58);
        chk("mul_chigh", bus.C_High, 8'h02);
        chk("mul_cvze", {bus.Carry, bus.Overflow, bus.Zero, bus.Error}, 4'b1000);
        handshake();

        // DIV 100/7 = 14 r 2
        do_op(4'd10, 8'd100, 8'd7, lat);
        chk("div_lat", lat, 9);
        chk("div_c", bus.C, 8'd14);
        chk("div_chigh", bus.C_High, 8'd2);
        chk("div_cvze", {bus.Carry, bus.Overflow, bus.Zero, bus.Error}, 4'b0000);
        handshake();

        // DIV by zero
        do_op(4'd10, 8'd55, 8'd0, lat);
        chk("div0_lat", lat, 1);
        chk("div0_c", bus.C, 8'hFF);
        chk("div0_chigh", bus.C_High, 8'd55);
        chk("div0_err", bus.Error, 1);
        handshake();

        // Illegal opcode
        do_op(4'd13, 8'h12, 8'h34, lat);
        chk("ill_c", {bus.C, bus.C_High}, 16'h0000);
        chk("ill_flags", {bus.Carry, bus.Overflow, bus.Zero, bus.Error}, 4'b0011);
        handshake();

        // Logic and shift ops
        do_op(4'd5, 8'h3C, 8'h00, lat);
        chk("not_c", bus.C, 8'hC3);
        handshake();
        do_op(4'd3, 8'hA0, 8'h05, lat);
        chk("or_c", bus.C, 8'hA5);
        handshake();
        do_op(4'd6, 8'h81, 8'h0B, lat);
        chk("shl_c", bus.C, 8'h08);
        handshake();
        do_op(4'd7, 8'h81, 8'h0A, lat);
        chk("shr_c", bus.C, 8'h20);
        handshake();

        // Back-pressure: DONE held with In_Valid pulses ignored
        do_op(4'd4, 8'h5A, 8'h0F, lat);
        chk("xor_c", bus.C, 8'h55);
        for (int i = 0; i < 5; i++) begin
            bus.In_Valid = i[0];
            bus.A        = 8'hFF;
            bus.B        = 8'h01;
            bus.Control  = 4'd0;
            step();
            chk("stall_hold", {bus.Out_Valid, bus.In_Ready, bus.C, bus.Zero}, {2'b10, 8'h55, 1'b0});
        end
        bus.In_Valid = 1'b0;
        handshake();
        chk("stall_idle_c", {bus.Out_Valid, bus.C}, {1'b0, 8'h55});
        do_op(4'd2, 8'hF0, 8'h3C, lat);
        chk("and_after_stall", bus.C, 8'h30);
        handshake();

        // Reset during the 4th cycle of a MUL
        bus.Control  = 4'd9;
        bus.A        = 8'd15;
        bus.B        = 8'd17;
        bus.In_Valid = 1'b1;
        step();
        bus.In_Valid = 1'b0;
        step();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_c", {bus.C, bus.C_High}, 16'h0000);
        chk("midrst_flags", {bus.Carry, bus.Overflow, bus.Zero, bus.Error, bus.Out_Valid},
            5'b00100);
        step();
        reset = 1'b1;
        step();
        chk("midrst_ready", bus.In_Ready, 1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.Out_Valid !== 1'b0) seen_valid = 1'b1;
        end
        chk("midrst_no_valid", seen_valid, 0);
        do_op(4'd8, 8'h80, 8'd3, lat);
        chk("sra_lat", lat, 1);
        chk("sra_c", bus.C, 8'hF0);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calculator_core.md
# calculator_core

Parametrised successor to the six-bit registered calculator. It accepts one operation at a time through a valid/ready handshake and executes single-cycle ALU operations directly. Multiply and divide run iteratively over Word_Length cycles, and the result is held until the consumer accepts it. The block sits between the operand/control source and the result sink, and replaces the fixed-width register-ALU-register top level.

## Interface
- Word_Length, 8, operand/result width (≥4, power of two)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- A  in  Word_Length  operand A (unsigned; signed only for Overflow and SRA)
- B  in  Word_Length  operand B
- Control  in  4  opcode
- In_Valid  in  1  operands/opcode valid
- In_Ready  out  1  block can accept an operation
- C  out  Word_Length  result (low half for MUL, quotient for DIV)
- C_High  out  Word_Length  high product half (MUL), remainder (DIV), else 0
- Carry  out  1  carry/borrow/product-overflow flag
- Overflow  out  1  signed overflow (ADD/SUB only)
- Zero  out  1  C == 0
- Error  out  1  divide-by-zero or illegal opcode
- Out_Valid  out  1  result valid
- Out_Ready  in  1  consumer accepts result

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR logical, 8 SRA, 9 MUL unsigned, 10 DIV unsigned, 11–15 illegal.
- Shift amount is B[log2(Word_Length)-1:0]; upper bits of B are ignored.
- ADD: Carry = carry-out. SUB: Carry = borrow (A < B). ADD/SUB Overflow = two's-complement overflow.
- All other ops: Carry = 0 and Overflow = 0, except MUL: Carry = (C_High != 0).
- DIV by zero: C = all ones, C_High = A, Error = 1. Illegal opcode: C = 0, C_High = 0, Error = 1, Zero = 1.
- FSM states:
  - IDLE: In_Ready = 1. An accept (In_Valid & In_Ready) registers A, B and Control. MUL/DIV with a nonzero divisor go to EXEC; all others go to DONE.
  - EXEC: the iterative unit runs exactly Word_Length steps (shift-add multiply, restoring divide), then goes to DONE.
  - DONE: Out_Valid = 1; outputs are stable. Out_Valid & Out_Ready returns to IDLE.
- In_Ready = 0 in EXEC and DONE. Inputs are ignored outside IDLE.
- Outputs are registered and change only on entry to DONE. They keep their last values in IDLE.

## Timing
- Reset (asynchronous, reset = 0): state IDLE; C, C_High, Carry, Overflow, Error, Out_Valid = 0; Zero = 1; In_Ready = 1 one cycle after deassertion; iterative unit cleared.
- Reset mid-EXEC or mid-DONE aborts the operation. The result is discarded and no Out_Valid is produced.
- Single-cycle ops: accept at edge k; Out_Valid high after edge k+1.
- MUL/DIV: accept at edge k; Out_Valid high after edge k+1+Word_Length.
- Handshake completes on the edge where Out_Valid & Out_Ready are both 1. In_Ready rises after that edge. The next accept occurs no earlier than the following edge.
- Out_Ready held high in advance gives one result per 3 cycles (simple ops) or Word_Length+3 cycles (MUL/DIV).
- Out_Ready low holds DONE indefinitely with all outputs unchanged.

## Structure
- Package calculator_pkg: opcode enumeration, FSM state enumeration, and a localparam for shift-amount width.
- Sub-module calc_muldiv:
  - Inputs: start, op select, operands. Outputs: done pulse, low/high result.
  - Holds the Word_Length-step counter and 2×Word_Length accumulator.
  - Instantiated once. calculator_core contains the FSM, the single-cycle ALU, and the output registers.

## Test plan
- Word_Length=8, ADD 200+100 → C=0x2C, Carry=1, Overflow=0. ADD 100+100 → C=0xC8, Overflow=1. Out_Valid one cycle after accept.
- SUB 5−7 → C=0xFE, Carry=1, Overflow=0, Zero=0. SUB 9−9 → C=0, Zero=1.
- MUL 200×3 → C=0x58, C_High=0x02, Carry=1, Out_Valid exactly 9 cycles after accept. DIV 100/7 → C=14, C_High=2, Error=0.
- DIV 55/0 → C=0xFF, C_High=55, Error=1, latency 1 cycle. Opcode 13 → C=0, Error=1, Zero=1.
- Out_Ready low for 5 cycles in DONE → outputs and Out_Valid stable, In_Ready=0, In_Valid pulses ignored. Out_Ready high → IDLE; next op accepted.
- reset asserted during cycle 4 of MUL → all outputs at reset values immediately, no Out_Valid. The first op after release executes correctly (SRA 0x80 by 3 → 0xF0).
